// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding, the
// default access timeout and the memory-operation decode.
package mem_stage_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    MOP_NONE  = 2'b00,
    MOP_LOAD  = 2'b01,
    MOP_STORE = 2'b10
  } mem_op_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 15;
  localparam logic [1:0] WORD_ALIGNED = 2'b00;

  // A store wins when both MemWriteE and MemtoRegE are raised.
  function automatic mem_op_e decode_mem_op(input logic mem_write, input logic mem_to_reg);
    mem_op_e op;
    if (mem_write) begin
      op = MOP_STORE;
    end else if (mem_to_reg) begin
      op = MOP_LOAD;
    end else begin
      op = MOP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: IDLE/WAIT FSM, WAIT-cycle timeout counter,
// request/stall generation. Optional alignment check under MEM_ALIGN_CHECK_EN.
module mem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemWriteE,
  input  logic        MemtoRegE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall_out,
  output logic        timeout_err,
  output logic        misalign_err,
  output logic        start_s,
  output logic        ack_done_s,
  output logic        misalign_s
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  mem_op_e          mem_op_s;
  logic             lsb_ok_s;
  logic             timeout_hit_s;
  logic             stall_s;

`ifdef MEM_ALIGN_CHECK_EN
  assign lsb_ok_s = (ALUOutE[1:0] == WORD_ALIGNED);
`else
  logic unused_lsb_s;
  assign unused_lsb_s = ^ALUOutE[1:0];
  assign lsb_ok_s     = 1'b1;
`endif

  // Next-step decode: accept, complete, time out or refuse an access.
  always_comb begin
    mem_op_s      = decode_mem_op(MemWriteE, MemtoRegE);
    start_s       = 1'b0;
    ack_done_s    = 1'b0;
    timeout_hit_s = 1'b0;
    misalign_s    = 1'b0;
    stall_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_op_s != MOP_NONE) begin
          misalign_s = ~lsb_ok_s;
          start_s    = lsb_ok_s;
          stall_s    = lsb_ok_s;
        end else begin
          start_s = 1'b0;
        end
      end
      ST_WAIT: begin
        ack_done_s    = mem_ack;
        timeout_hit_s = ~mem_ack & (cnt_r == CNT_LAST);
        stall_s       = ~(mem_ack | timeout_hit_s);
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // Reset must drop the stall at once, even mid-WAIT.
  assign stall_out = stall_s & ~RESET;

  // FSM, timeout counter and registered request outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 30'h0;
      mem_wdata    <= 32'h0;
      timeout_err  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign_s;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r   <= ST_WAIT;
            cnt_r     <= '0;
            mem_req   <= 1'b1;
            mem_we    <= (mem_op_s == MOP_STORE);
            mem_addr  <= ALUOutE[31:2];
            mem_wdata <= WriteDataE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (ack_done_s || timeout_hit_s) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'h0;
            mem_wdata <= 32'h0;
            if (timeout_hit_s) begin
              timeout_err <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory access sequencing, IF redirect and MEM/WB
// register. Define MEM_ALIGN_CHECK_EN to refuse word-misaligned accesses.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        ZeroE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCBranchE,
  input  logic [4:0]  wb_addrE,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        PCSrc,
  output logic [31:0] PC_next_jumpOrBranch,
  output logic        stall_out,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic [31:0] ALUOutM,
  output logic [31:0] ReadDataM,
  output logic [4:0]  wb_addrM,
  output logic        timeout_err,
  output logic        misalign_err
);

  logic start_s;
  logic ack_done_s;
  logic misalign_s;

  mem_req_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .CLK         (CLK),
    .RESET       (RESET),
    .MemWriteE   (MemWriteE),
    .MemtoRegE   (MemtoRegE),
    .ALUOutE     (ALUOutE),
    .WriteDataE  (WriteDataE),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .stall_out   (stall_out),
    .timeout_err (timeout_err),
    .misalign_err(misalign_err),
    .start_s     (start_s),
    .ack_done_s  (ack_done_s),
    .misalign_s  (misalign_s)
  );

  // IF-stage redirect, forced low while reset is held.
  always_comb begin
    if (RESET) begin
      PCSrc                = 1'b0;
      PC_next_jumpOrBranch = 32'h0;
    end else begin
      PCSrc                = (BranchE & ZeroE) | JumpE;
      PC_next_jumpOrBranch = PCBranchE;
    end
  end

  // MEM/WB register: bubble while an access is pending, refused or timed out.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      ALUOutM   <= 32'h0;
      ReadDataM <= 32'h0;
      wb_addrM  <= 5'h0;
    end else if (ack_done_s) begin
      RegWriteM <= RegWriteE & ~MemWriteE;
      MemtoRegM <= MemtoRegE & ~MemWriteE;
      ALUOutM   <= ALUOutE;
      wb_addrM  <= wb_addrE;
      if (decode_mem_op(MemWriteE, MemtoRegE) == MOP_LOAD) begin
        ReadDataM <= mem_rdata;
      end
    end else if (mem_req || start_s || misalign_s) begin
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
    end else begin
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      ALUOutM   <= ALUOutE;
      wb_addrM  <= wb_addrE;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scoreboard of expected MEM/WB
// results plus direct checks of request, stall, redirect, error and reset.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, ZeroE;
  logic [31:0] ALUOutE, WriteDataE, PCBranchE;
  logic [4:0]  wb_addrE;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        PCSrc;
  logic [31:0] PC_next_jumpOrBranch;
  logic        stall_out;
  logic        RegWriteM, MemtoRegM;
  logic [31:0] ALUOutM, ReadDataM;
  logic [4:0]  wb_addrM;
  logic        timeout_err, misalign_err;

  always #5 CLK = ~CLK;

  mem_access_stage #(.TIMEOUT_CYCLES(15)) dut (
    .CLK(CLK), .RESET(RESET),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ZeroE(ZeroE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .PCBranchE(PCBranchE),
    .wb_addrE(wb_addrE),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .PCSrc(PCSrc), .PC_next_jumpOrBranch(PC_next_jumpOrBranch),
    .stall_out(stall_out),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .ALUOutM(ALUOutM),
    .ReadDataM(ReadDataM), .wb_addrM(wb_addrM),
    .timeout_err(timeout_err), .misalign_err(misalign_err)
  );

  typedef struct {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu_out;
    logic [31:0] read_data;
    logic [4:0]  wb_addr;
    logic        full;
  } exp_t;

  exp_t        exp_q[$];
  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] rd_model  = 32'h0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_nop();
    RegWriteE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0;
    BranchE = 1'b0; JumpE = 1'b0; ZeroE = 1'b0;
    ALUOutE = 32'h0; WriteDataE = 32'h0; PCBranchE = 32'h0; wb_addrE = 5'h0;
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_value({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_value({name, "_RegWriteM"}, 32'(RegWriteM), 32'(e.reg_write));
      check_value({name, "_ReadDataM"}, ReadDataM, e.read_data);
      if (e.full) begin
        check_value({name, "_MemtoRegM"}, 32'(MemtoRegM), 32'(e.mem_to_reg));
        check_value({name, "_ALUOutM"}, ALUOutM, e.alu_out);
        check_value({name, "_wb_addrM"}, 32'(wb_addrM), 32'(e.wb_addr));
      end
    end
  endtask

  // ack_after < 0 means the memory never answers.
  task automatic run_op(input string name, input logic ld, input logic st, input logic rw,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wb,
                        input int ack_after, input logic [31:0] rdata);
    exp_t e;
    int   stalls = 0;
    int   waits  = 0;
    int   exp_waits;
    bit   done   = 1'b0;
    @(posedge CLK); #1;
    RegWriteE = rw; MemtoRegE = ld; MemWriteE = st;
    ALUOutE = addr; WriteDataE = wdata; wb_addrE = wb;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    exp_waits = (ld | st) ? ((ack_after < 0) ? 15 : ack_after + 1) : 0;
    e.full       = !((ld | st) && ack_after < 0);
    e.reg_write  = e.full ? (rw & ~st) : 1'b0;
    e.mem_to_reg = ld & ~st;
    e.alu_out    = addr;
    e.wb_addr    = wb;
    if (ld && !st && ack_after >= 0) rd_model = rdata;
    e.read_data  = rd_model;
    exp_q.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (mem_req) begin
        waits++;
        if (waits == 1) begin
          check_value({name, "_mem_addr"}, 32'(mem_addr), 32'(addr[31:2]));
          check_value({name, "_mem_we"}, 32'(mem_we), 32'(st));
          if (st) check_value({name, "_mem_wdata"}, mem_wdata, wdata);
        end
        mem_ack   = (ack_after >= 0) && (waits > ack_after);
        mem_rdata = mem_ack ? rdata : 32'h0;
      end
      #1;
      if (stall_out) stalls++;
      else done = 1'b1;
      @(posedge CLK); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
    end
    set_nop();
    if (!done) check_value({name, "_cycle_bound"}, 32'd0, 32'd1);
    check_value({name, "_wait_cycles"}, 32'(waits), 32'(exp_waits));
    check_value({name, "_stall_cycles"}, 32'(stalls), 32'(exp_waits));
    @(negedge CLK);
    compare_out(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] alu_vals [3];
    logic [4:0]  alu_wbs  [3];
    alu_vals[0] = 32'h0000_0010; alu_wbs[0] = 5'd5;
    alu_vals[1] = 32'hFFFF_FFFF; alu_wbs[1] = 5'd31;
    alu_vals[2] = 32'h8000_0003; alu_wbs[2] = 5'd1;

    RESET = 1'b1; set_nop(); mem_ack = 1'b0; mem_rdata = 32'h0;
    MemtoRegE = 1'b1;
    repeat (2) @(negedge CLK);
    check_value("rst_mem_req", 32'(mem_req), 32'd0);
    check_value("rst_stall", 32'(stall_out), 32'd0);
    check_value("rst_RegWriteM", 32'(RegWriteM), 32'd0);
    check_value("rst_ALUOutM", ALUOutM, 32'h0);
    check_value("rst_ReadDataM", ReadDataM, 32'h0);
    check_value("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_value("rst_misalign_err", 32'(misalign_err), 32'd0);
    set_nop();
    RESET = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_op($sformatf("alu%0d", i), 1'b0, 1'b0, 1'b1, alu_vals[i], 32'h0, alu_wbs[i], 0, 32'h0);
    end
    run_op("alu_norw", 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 5'd9, 0, 32'h0);
    run_op("load_0x20", 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
    run_op("store_0x40", 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_1234, 5'd8, 1, 32'h0);
    run_op("load_fast", 1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 5'd12, 0, 32'hCAFE_F00D);
    run_op("store_wins", 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_55AA, 5'd4, 2, 32'h1111_2222);

    run_op("load_timeout", 1'b1, 1'b0, 1'b1, 32'h0000_0060, 32'h0, 5'd3, -1, 32'h0);
    check_value("to_err_set", 32'(timeout_err), 32'd1);
    check_value("to_stall", 32'(stall_out), 32'd0);
    check_value("to_idle", 32'(mem_req), 32'd0);
    run_op("alu_after_to", 1'b0, 1'b0, 1'b1, 32'h0000_0ABC, 32'h0, 5'd6, 0, 32'h0);
    check_value("to_err_sticky", 32'(timeout_err), 32'd1);

    BranchE = 1'b1; ZeroE = 1'b1; PCBranchE = 32'h0000_0100;
    #1;
    check_value("br_taken_pcsrc", 32'(PCSrc), 32'd1);
    check_value("br_target", PC_next_jumpOrBranch, 32'h0000_0100);
    ZeroE = 1'b0;
    #1;
    check_value("br_not_taken", 32'(PCSrc), 32'd0);
    BranchE = 1'b0; JumpE = 1'b1; PCBranchE = 32'h0000_2000;
    #1;
    check_value("jump_pcsrc", 32'(PCSrc), 32'd1);
    check_value("jump_target", PC_next_jumpOrBranch, 32'h0000_2000);
    set_nop();

`ifdef MEM_ALIGN_CHECK_EN
    @(posedge CLK); #1;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; ALUOutE = 32'h0000_0022; wb_addrE = 5'd3;
    @(negedge CLK);
    check_value("mis_no_stall", 32'(stall_out), 32'd0);
    @(posedge CLK); #1;
    set_nop();
    @(negedge CLK);
    check_value("mis_err_pulse", 32'(misalign_err), 32'd1);
    check_value("mis_no_req", 32'(mem_req), 32'd0);
    check_value("mis_bubble", 32'(RegWriteM), 32'd0);
    @(negedge CLK);
    check_value("mis_err_clear", 32'(misalign_err), 32'd0);
`else
    run_op("unaligned_ld", 1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0, 5'd3, 0, 32'h0BAD_CAFE);
    check_value("mis_err_tied", 32'(misalign_err), 32'd0);
`endif

    // Reset in the second WAIT cycle of a load, then a late ack.
    @(posedge CLK); #1;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; ALUOutE = 32'h0000_0030; wb_addrE = 5'd2;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_value("pre_rst_req", 32'(mem_req), 32'd1);
    RESET = 1'b1;
    #1;
    check_value("midrst_req", 32'(mem_req), 32'd0);
    check_value("midrst_stall", 32'(stall_out), 32'd0);
    check_value("midrst_to_err", 32'(timeout_err), 32'd0);
    set_nop();
    @(negedge CLK);
    RESET = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(posedge CLK); #1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge CLK);
    check_value("late_ack_req", 32'(mem_req), 32'd0);
    check_value("late_ack_regwrite", 32'(RegWriteM), 32'd0);
    check_value("late_ack_readdata", ReadDataM, 32'h0);
    check_value("late_ack_stall", 32'(stall_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the maximum number of WAIT cycles before a memory access is abandoned.
REQ-002 CLK  in  1  SHALL be the single clock; all state SHALL update on its posedge.
REQ-003 RESET  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, ZeroE  in  1 each  SHALL carry the EX-stage control signals and ALU zero flag.
REQ-005 ALUOutE, WriteDataE, PCBranchE  in  32 each  SHALL carry the ALU result/address, store data and branch/jump target.
REQ-006 wb_addrE  in  5  SHALL carry the destination register.
REQ-007 mem_req, mem_we  out  1; mem_addr  out  30 (word address); mem_wdata  out  32  SHALL form the data-memory request.
REQ-008 mem_ack  in  1; mem_rdata  in  32  SHALL form the data-memory response.
REQ-009 PCSrc, PC_next_jumpOrBranch  out  1/32  SHALL drive the IF-stage redirect.
REQ-010 stall_out  out  1  SHALL tell upstream stages to hold their outputs.
REQ-011 RegWriteM, MemtoRegM  out  1; ALUOutM, ReadDataM  out  32; wb_addrM  out  5  SHALL be the MEM/WB pipeline register.
REQ-012 timeout_err, misalign_err  out  1  SHALL flag access errors.

Function
REQ-013 Memory op SHALL be MemWriteE=1 (store, wins if MemtoRegE also 1) or MemtoRegE=1 (load).
REQ-014 FSM SHALL have states IDLE and WAIT; IDLE->WAIT on a memory op at posedge; WAIT->IDLE on mem_ack or on timeout.
REQ-015 mem_req SHALL equal (state==WAIT); mem_we, mem_addr=ALUOutE[31:2], mem_wdata SHALL be driven from held EX inputs while in WAIT.
REQ-016 stall_out SHALL be combinational: 1 when (IDLE and memory op) or (WAIT and not completing this cycle).
REQ-017 Non-memory op in IDLE: MEM/WB register SHALL capture inputs next posedge (1-cycle latency), ReadDataM unchanged.
REQ-018 Load: on the mem_ack posedge, ReadDataM SHALL capture mem_rdata and RegWriteM/MemtoRegM/ALUOutM/wb_addrM SHALL capture inputs (minimum 2-cycle latency).
REQ-019 Store: on the mem_ack posedge, RegWriteM SHALL be 0.
REQ-020 While in WAIT without completion, RegWriteM SHALL be 0 (bubble).
REQ-021 A WAIT cycle counter SHALL reset on entry; if it reaches TIMEOUT_CYCLES without mem_ack, FSM SHALL return to IDLE, RegWriteM=0, timeout_err SHALL set and stay set until reset.
REQ-022 mem_ack outside WAIT SHALL be ignored.
REQ-023 PCSrc SHALL be combinational (BranchE & ZeroE) | JumpE; PC_next_jumpOrBranch SHALL equal PCBranchE.

Reset
REQ-024 RESET SHALL immediately force IDLE, counter 0, all outputs 0 (including mem_req, stall_out, errors), also when asserted mid-WAIT; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-025 With MEM_ALIGN_CHECK_EN defined, a memory op with ALUOutE[1:0]!=0 SHALL not enter WAIT, SHALL not stall, SHALL pulse misalign_err for one cycle and SHALL insert RegWriteM=0.
REQ-026 Without MEM_ALIGN_CHECK_EN, ALUOutE[1:0] SHALL be ignored and misalign_err SHALL be tied 0.

Structure
REQ-027 Package mem_stage_pkg SHALL hold the FSM state encoding, default TIMEOUT_CYCLES and the memory-op decode constants.
REQ-028 Sub-module mem_req_fsm SHALL contain the FSM, timeout counter and stall/request generation; the pipeline register SHALL stay in mem_access_stage.

Verification
REQ-029 ALU op ALUOutE=0x0000_0010, wb_addrE=5, RegWriteE=1 -> next cycle ALUOutM=0x10, wb_addrM=5, RegWriteM=1, stall_out never 1.
REQ-030 Load addr 0x20, mem_ack after 3 WAIT cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x8, stall_out=1 for 4 cycles, then ReadDataM=0xDEADBEEF, MemtoRegM=1.
REQ-031 Store addr 0x40, data 0x1234 -> mem_we=1, mem_wdata=0x1234 in WAIT; RegWriteM=0 after ack.
REQ-032 Load with no mem_ack -> after 15 WAIT cycles state IDLE, timeout_err=1, stall_out=0.
REQ-033 RESET asserted in 2nd WAIT cycle -> mem_req and stall_out 0 immediately; following mem_ack leaves outputs 0.
REQ-034 BranchE=1, ZeroE=1, PCBranchE=0x100 -> PCSrc=1, PC_next_jumpOrBranch=0x100 same cycle; with MEM_ALIGN_CHECK_EN, load addr 0x22 -> misalign_err one-cycle pulse, no mem_req.
